// File: rtl/sdram_layer_pkg.sv
// Shared state encoding, mode constants and default widths for the
// SDRAM fully-connected layer engine.
package sdram_layer_pkg;

    localparam int DEF_DW    = 16;
    localparam int DEF_AW    = 32;
    localparam int DEF_ACC_W = 40;
    localparam int DEF_FRAC  = 8;
    localparam int DEF_SZ_W  = 16;

    typedef logic [3:0] state_t;

    localparam state_t S_IDLE   = 4'd0;
    localparam state_t S_RD_X   = 4'd1;
    localparam state_t S_RD_W   = 4'd2;
    localparam state_t S_MAC    = 4'd3;
    localparam state_t S_WR     = 4'd4;
    localparam state_t S_NEXT_J = 4'd5;
    localparam state_t S_DONE   = 4'd6;

    localparam logic MODE_BIN = 1'b0;
    localparam logic MODE_MAC = 1'b1;

endpackage

// File: rtl/layer_mac_unit.sv
// Accumulator for one output neuron plus combinational post-processing
// (Q-format shift, optional ReLU, saturation to the element width).
module layer_mac_unit
    import sdram_layer_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int ACC_W = DEF_ACC_W,
    parameter int FRAC  = DEF_FRAC
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clear,
    input  logic          acc_en,
    input  logic          skip,
    input  logic          mode,
    input  logic          relu_en,
    input  logic [DW-1:0] w,
    input  logic [DW-1:0] x,
    output logic [DW-1:0] result
);

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  addend;
    logic signed [ACC_W-1:0]  scaled;
    logic signed [2*DW-1:0]   prod;

    always_comb begin
        prod = $signed({{DW{w[DW-1]}}, w}) * $signed({{DW{x[DW-1]}}, x});
        if (mode == MODE_MAC) addend = {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
        else                  addend = {{(ACC_W-DW){w[DW-1]}}, w};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)              acc <= '0;
        else if (clear)            acc <= '0;
        else if (acc_en && !skip)  acc <= acc + addend;
    end

    always_comb begin
        scaled = (mode == MODE_MAC) ? (acc >>> FRAC) : acc;
        if (relu_en && (scaled < 0)) scaled = '0;
        if (scaled > SAT_MAX)      result = {1'b0, {(DW-1){1'b1}}};
        else if (scaled < SAT_MIN) result = {1'b1, {(DW-1){1'b0}}};
        else                       result = scaled[DW-1:0];
    end

endmodule

// File: rtl/sdram_layer_engine.sv
// Fully-connected layer engine: reads x and row-major w over an Avalon-MM
// master, accumulates per output, writes saturated results back.
//
// state  | meaning
// IDLE   | waiting for start; latches config on acceptance
// RD_X   | read x[i] (request, then wait for readdatavalid)
// RD_W   | read w at weight pointer
// MAC    | accumulate (or skip), advance i and weight pointer
// WR     | write post-processed result to y[j]
// NEXT_J | advance to next output, clear accumulator
// DONE   | done asserted until start drops
module sdram_layer_engine
    import sdram_layer_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int AW    = DEF_AW,
    parameter int ACC_W = DEF_ACC_W,
    parameter int FRAC  = DEF_FRAC,
    parameter int SZ_W  = DEF_SZ_W
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            mode,
    input  logic            relu_en,
    input  logic [AW-1:0]   w_base,
    input  logic [AW-1:0]   x_base,
    input  logic [AW-1:0]   y_base,
    input  logic [SZ_W-1:0] in_size,
    input  logic [SZ_W-1:0] out_size,
    output logic            busy,
    output logic            done,
    output logic [3:0]      state,
    output logic [AW-1:0]   address,
    output logic            read_n,
    output logic            write_n,
    output logic            chipselect,
    output logic [DW/8-1:0] byteenable,
    output logic [DW-1:0]   writedata,
    input  logic            waitrequest,
    input  logic            readdatavalid,
    input  logic [DW-1:0]   readdata
);

    logic            mode_q, relu_q, rd_wait, skip;
    logic [AW-1:0]   x_base_q, y_base_q, wp;
    logic [SZ_W-1:0] in_q, out_q, i, j, i_nxt, j_nxt;
    logic [DW-1:0]   x_cur, w_cur, mac_result;
    logic            mac_clear, mac_en;

    assign i_nxt      = i + 1'b1;
    assign j_nxt      = j + 1'b1;
    assign chipselect = 1'b1;
    assign byteenable = '1;
    assign busy       = (state != S_IDLE) && (state != S_DONE);
    assign done       = (state == S_DONE);
    // acc is stable for the whole WR state, so the result can drive the bus directly
    assign writedata  = (state == S_WR) ? mac_result : '0;
    assign mac_clear  = ((state == S_IDLE) && start) || (state == S_NEXT_J);
    assign mac_en     = (state == S_MAC);

    layer_mac_unit #(.DW(DW), .ACC_W(ACC_W), .FRAC(FRAC)) u_mac (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (mac_clear),
        .acc_en  (mac_en),
        .skip    (skip),
        .mode    (mode_q),
        .relu_en (relu_q),
        .w       (w_cur),
        .x       (x_cur),
        .result  (mac_result)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            address  <= '0;
            read_n   <= 1'b1;
            write_n  <= 1'b1;
            mode_q   <= 1'b0;
            relu_q   <= 1'b0;
            rd_wait  <= 1'b0;
            skip     <= 1'b0;
            x_base_q <= '0;
            y_base_q <= '0;
            wp       <= '0;
            in_q     <= '0;
            out_q    <= '0;
            i        <= '0;
            j        <= '0;
            x_cur    <= '0;
            w_cur    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mode_q   <= mode;
                        relu_q   <= relu_en;
                        x_base_q <= x_base;
                        y_base_q <= y_base;
                        in_q     <= in_size;
                        out_q    <= out_size;
                        wp       <= w_base;
                        i        <= '0;
                        j        <= '0;
                        rd_wait  <= 1'b0;
                        if (out_size == '0) begin
                            state <= S_DONE;
                        end else if (in_size == '0) begin
                            state   <= S_WR;
                            write_n <= 1'b0;
                            address <= y_base;
                        end else begin
                            state   <= S_RD_X;
                            read_n  <= 1'b0;
                            address <= x_base;
                        end
                    end
                end
                S_RD_X, S_RD_W: begin
                    if (!rd_wait) begin
                        if (!waitrequest) begin
                            read_n  <= 1'b1;
                            rd_wait <= 1'b1;
                        end
                    end else if (readdatavalid) begin
                        rd_wait <= 1'b0;
                        if (state == S_RD_W) begin
                            w_cur <= readdata;
                            skip  <= 1'b0;
                            state <= S_MAC;
                        end else begin
                            x_cur <= readdata;
                            if ((mode_q == MODE_BIN) && (readdata == '0)) begin
                                skip  <= 1'b1;
                                state <= S_MAC;
                            end else begin
                                skip    <= 1'b0;
                                state   <= S_RD_W;
                                read_n  <= 1'b0;
                                address <= wp;
                            end
                        end
                    end
                end
                S_MAC: begin
                    i  <= i_nxt;
                    wp <= wp + AW'(2);
                    if (i_nxt == in_q) begin
                        state   <= S_WR;
                        write_n <= 1'b0;
                        address <= y_base_q + (AW'(j) << 1);
                    end else begin
                        state   <= S_RD_X;
                        read_n  <= 1'b0;
                        address <= x_base_q + (AW'(i_nxt) << 1);
                    end
                end
                S_WR: begin
                    if (!waitrequest) begin
                        write_n <= 1'b1;
                        state   <= S_NEXT_J;
                    end
                end
                S_NEXT_J: begin
                    j <= j_nxt;
                    i <= '0;
                    if (j_nxt == out_q) begin
                        state <= S_DONE;
                    end else if (in_q == '0) begin
                        state   <= S_WR;
                        write_n <= 1'b0;
                        address <= y_base_q + (AW'(j_nxt) << 1);
                    end else begin
                        state   <= S_RD_X;
                        read_n  <= 1'b0;
                        address <= x_base_q;
                    end
                end
                S_DONE: begin
                    if (!start) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_layer_engine.sv
// Bench for sdram_layer_engine: Avalon slave with random stalls/latency,
// word memory and an arithmetic reference model of the layer.
module tb_sdram_layer_engine;
    import sdram_layer_pkg::*;

    localparam int DW = 16, AW = 32, ACC_W = 40, FRAC = 8, SZ_W = 16;
    localparam logic [AW-1:0] XB = 32'h100, WB = 32'h400, YB = 32'hC00;
    localparam int XI = 'h80, WI = 'h200;

    logic            clk = 1'b0, reset_n = 1'b1, start = 1'b0, mode = 1'b0, relu_en = 1'b0;
    logic [AW-1:0]   w_base = WB, x_base = XB, y_base = YB;
    logic [SZ_W-1:0] in_size = '0, out_size = '0;
    logic            busy, done, read_n, write_n, chipselect;
    logic [3:0]      state;
    logic [AW-1:0]   address;
    logic [DW/8-1:0] byteenable;
    logic [DW-1:0]   writedata;
    logic            waitrequest = 1'b0, readdatavalid = 1'b0;
    logic [DW-1:0]   readdata = '0;

    sdram_layer_engine #(.DW(DW), .AW(AW), .ACC_W(ACC_W), .FRAC(FRAC), .SZ_W(SZ_W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .mode(mode), .relu_en(relu_en),
        .w_base(w_base), .x_base(x_base), .y_base(y_base),
        .in_size(in_size), .out_size(out_size),
        .busy(busy), .done(done), .state(state), .address(address),
        .read_n(read_n), .write_n(write_n), .chipselect(chipselect),
        .byteenable(byteenable), .writedata(writedata),
        .waitrequest(waitrequest), .readdatavalid(readdatavalid), .readdata(readdata)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // slave memory and bus bookkeeping
    logic [15:0]   mem [0:2047];
    bit            wait_en = 0;
    int            max_lat = 1;
    bit            rd_pend = 0;
    int            rd_cnt = 0;
    logic [15:0]   rd_data = '0;
    int            n_xrd = 0, n_wrd = 0;
    logic [AW-1:0] wr_addr_q[$];
    logic [DW-1:0] wr_data_q[$];
    bit            p_valid = 0, p_rd_low = 0, p_wr_low = 0;
    logic [AW-1:0] p_addr = '0;
    logic [DW-1:0] p_wdata = '0;

    always @(posedge clk) begin
        if (reset_n && p_valid) begin
            if (p_rd_low) check_val("rd_strobe_hold", read_n, 1'b0);
            if (p_wr_low) begin
                check_val("wr_strobe_hold", write_n, 1'b0);
                check_val("wr_data_hold", writedata, p_wdata);
            end
            check_val("addr_hold", address, p_addr);
        end
        p_valid  = reset_n && waitrequest && (!read_n || !write_n);
        p_rd_low = !read_n;
        p_wr_low = !write_n;
        p_addr   = address;
        p_wdata  = writedata;
        if (reset_n && !read_n && !waitrequest) begin
            check_val("one_outstanding", rd_pend, 1'b0);
            if (address >= WB && address < YB) n_wrd++;
            else n_xrd++;
            rd_pend = 1;
            rd_cnt  = $urandom_range(max_lat, 1);
            rd_data = mem[address[11:1]];
        end
        if (reset_n && !write_n && !waitrequest) begin
            wr_addr_q.push_back(address);
            wr_data_q.push_back(writedata);
        end
        #1;
        readdatavalid = 1'b0;
        if (rd_pend) begin
            if (rd_cnt <= 1) begin
                readdatavalid = 1'b1;
                readdata      = rd_data;
                rd_pend       = 0;
            end else begin
                rd_cnt--;
            end
        end
        waitrequest = wait_en ? 1'($urandom_range(1, 0)) : 1'b0;
    end

    function automatic logic [15:0] ref_y(input int jj, input int n_in, input bit md, input bit rl);
        longint acc = 0;
        longint r, x, w;
        for (int k = 0; k < n_in; k++) begin
            x = longint'(shortint'(mem[XI + k]));
            w = longint'(shortint'(mem[WI + jj*n_in + k]));
            if (!md) begin
                if (x != 0) acc += w;
            end else begin
                acc += w * x;
            end
        end
        r = md ? (acc >>> FRAC) : acc;
        if (rl && r < 0) r = 0;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return 16'(r);
    endfunction

    task automatic fill_rand(input bit md, input int n_in, input int n_out);
        for (int k = 0; k < n_in; k++)
            mem[XI + k] = (!md && $urandom_range(1, 0) == 1) ? 16'h0 : 16'($urandom);
        for (int k = 0; k < n_in*n_out; k++)
            mem[WI + k] = 16'($urandom);
    endtask

    task automatic run_layer(input string tag, input bit md, input bit rl,
                             input int n_in, input int n_out, input int exp_cyc);
        int cyc = 0;
        int nz = 0;
        n_xrd = 0; n_wrd = 0;
        wr_addr_q.delete(); wr_data_q.delete();
        for (int k = 0; k < n_in; k++) if (mem[XI + k] != 0) nz++;
        @(negedge clk);
        mode = md; relu_en = rl; in_size = SZ_W'(n_in); out_size = SZ_W'(n_out);
        start = 1'b1;
        do begin
            @(posedge clk); #2;
            cyc++;
            if (cyc == 1) begin
                check_val({tag, "_busy"}, busy, (n_out != 0));
                // config must be ignored once accepted
                mode = ~md; relu_en = ~rl; in_size = 16'($urandom); out_size = 16'($urandom);
                x_base = $urandom; w_base = $urandom; y_base = $urandom;
            end
        end while (!done && cyc < 4000);
        check_val({tag, "_done"}, done, 1'b1);
        check_val({tag, "_busy_done"}, busy, 1'b0);
        if (exp_cyc >= 0) check_val({tag, "_cycles"}, cyc, exp_cyc);
        check_val({tag, "_nwr"}, wr_addr_q.size(), n_out);
        check_val({tag, "_nxrd"}, n_xrd, n_in*n_out);
        check_val({tag, "_nwrd"}, n_wrd, (md ? n_in : nz) * n_out);
        for (int jj = 0; jj < n_out && jj < wr_addr_q.size(); jj++) begin
            check_val({tag, "_yaddr"}, wr_addr_q[jj], YB + 32'(2*jj));
            check_val({tag, "_y"}, wr_data_q[jj], ref_y(jj, n_in, md, rl));
        end
        @(negedge clk);
        start = 1'b0;
        x_base = XB; w_base = WB; y_base = YB;
        @(posedge clk); #2;
        check_val({tag, "_idle"}, state, S_IDLE);
        check_val({tag, "_done_low"}, done, 1'b0);
    endtask

    task automatic load_t1;
        mem[XI+0] = 16'd0; mem[XI+1] = 16'd3; mem[XI+2] = 16'd0; mem[XI+3] = 16'd1;
        mem[WI+0] = 16'd1; mem[WI+1] = 16'd2; mem[WI+2] = 16'd3; mem[WI+3] = 16'd4;
        mem[WI+4] = -16'sd5; mem[WI+5] = 16'd6; mem[WI+6] = 16'd7; mem[WI+7] = 16'd8;
    endtask

    task automatic check_first(input string tag, input logic [15:0] exp);
        if (wr_data_q.size() >= 1) check_val(tag, wr_data_q[0], exp);
        else check_val({tag, "_missing"}, 0, 1);
    endtask

    initial begin
        int cyc;
        for (int k = 0; k < 2048; k++) mem[k] = '0;
        #1 reset_n = 1'b0;
        #2;
        check_val("rst_read_n", read_n, 1'b1);
        check_val("rst_write_n", write_n, 1'b1);
        check_val("rst_address", address, 0);
        check_val("rst_writedata", writedata, 0);
        check_val("rst_state", state, S_IDLE);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_done", done, 1'b0);
        check_val("rst_chipselect", chipselect, 1'b1);
        check_val("rst_byteenable", byteenable, 2'b11);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // binary gate, zero-wait: y = {6, 14}, best-case cycle count
        load_t1();
        run_layer("bin", 1'b0, 1'b0, 4, 2, 37);
        check_first("bin_y0", 16'd6);
        if (wr_data_q.size() >= 2) check_val("bin_y1", wr_data_q[1], 16'd14);
        else check_val("bin_y1_missing", 0, 1);

        // same layer with random stalls and latency
        wait_en = 1; max_lat = 5;
        run_layer("bin_wait", 1'b0, 1'b0, 4, 2, -1);
        check_first("bin_wait_y0", 16'd6);
        wait_en = 0; max_lat = 1;

        // signed MAC and ReLU
        mem[XI+0] = 16'h0100; mem[XI+1] = 16'h0200;
        mem[WI+0] = 16'h0180; mem[WI+1] = 16'hFF00;
        run_layer("mac", 1'b1, 1'b0, 2, 1, -1);
        check_first("mac_y", 16'hFF80);
        run_layer("mac_relu", 1'b1, 1'b1, 2, 1, -1);
        check_first("mac_relu_y", 16'h0000);

        // saturation both ways
        for (int k = 0; k < 4; k++) begin mem[XI+k] = 16'h7F00; mem[WI+k] = 16'h7F00; end
        run_layer("sat_pos", 1'b1, 1'b0, 4, 1, -1);
        check_first("sat_pos_y", 16'h7FFF);
        for (int k = 0; k < 4; k++) mem[WI+k] = 16'h8100;
        run_layer("sat_neg", 1'b1, 1'b0, 4, 1, -1);
        check_first("sat_neg_y", 16'h8000);

        // degenerate sizes
        run_layer("out0", 1'b1, 1'b0, 4, 0, 1);
        run_layer("in0", 1'b0, 1'b0, 0, 3, -1);

        // reset while waiting for weight data; stale readdatavalid must be ignored
        fill_rand(1'b1, 3, 2);
        max_lat = 5;
        @(negedge clk);
        mode = 1'b1; relu_en = 1'b0; in_size = 16'd3; out_size = 16'd2; start = 1'b1;
        cyc = 0;
        while (!(state == S_RD_W && read_n) && cyc < 200) begin @(posedge clk); #2; cyc++; end
        check_val("rst_mid_reached_rdw", state, S_RD_W);
        reset_n = 1'b0;
        start   = 1'b0;
        #1;
        check_val("rst_mid_read_n", read_n, 1'b1);
        check_val("rst_mid_state", state, S_IDLE);
        check_val("rst_mid_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(posedge clk);
        #2;
        check_val("rst_mid_still_idle", state, S_IDLE);
        run_layer("after_rst", 1'b1, 1'b0, 3, 2, -1);
        max_lat = 1;

        // randomized layers
        for (int t = 0; t < 10; t++) begin
            bit md, rl;
            int ni, no;
            md = 1'($urandom_range(1, 0));
            rl = 1'($urandom_range(1, 0));
            ni = $urandom_range(5, 1);
            no = $urandom_range(4, 1);
            wait_en = 1'($urandom_range(1, 0));
            max_lat = $urandom_range(5, 1);
            fill_rand(md, ni, no);
            run_layer($sformatf("rand%0d", t), md, rl, ni, no, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sdram_layer_engine.md
# sdram_layer_engine

Parametrised successor to the single-layer SDRAM master. It computes one fully-connected layer y[j] = f(Σ_i w[j][i]·x[i]) for j in [0, out_size), reading inputs and weights over a 16-bit Avalon-MM master port and writing results back to SDRAM. Base addresses and sizes are runtime inputs latched at start, and two arithmetic modes are supported: binary-gated add, and signed fixed-point MAC with optional ReLU and saturation. It sits between the HPS control registers (start/done) and the SDRAM controller slave.

## Interface
- DW, 16, data word width (bus width; elements are DW-bit signed)
- AW, 32, byte address width
- ACC_W, 40, accumulator width (signed)
- FRAC, 8, fractional bits of Q-format in MAC mode
- SZ_W, 16, width of in_size/out_size
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  level request from HPS; sampled in IDLE
- mode  in  1  0 = binary gate (add w if x≠0), 1 = signed MAC
- relu_en  in  1  clamp negative results to 0
- w_base, x_base, y_base  in  AW  byte base addresses
- in_size, out_size  in  SZ_W  element counts
- busy  out  1  high from start acceptance until DONE
- done  out  1  high in DONE until start falls
- state  out  4  current state, for board LEDs
- address  out  AW  Avalon byte address
- read_n, write_n  out  1  active-low strobes
- chipselect  out  1  constant 1
- byteenable  out  DW/8  constant all-ones
- writedata  out  DW  write data
- waitrequest, readdatavalid  in  1  Avalon slave handshakes
- readdata  in  DW  read data

## Operation
- States: IDLE(0), RD_X(1), RD_W(2), MAC(3), WR(4), NEXT_J(5), DONE(6).
- IDLE: start=1 latches all config ports, clears i, j, acc, and sets the weight pointer wp=w_base. Goes to RD_X, or to DONE if out_size=0.
- RD_X: read x_base+2·i into x_cur.
  - mode 0 and x_cur=0: skip the weight read. Advance i and wp by one element and go to MAC with the add suppressed.
  - Otherwise go to RD_W.
- RD_W: read from wp into w_cur, then go to MAC.
- MAC:
  - mode 0: acc += sext(w_cur).
  - mode 1: acc += sext(w_cur)·sext(x_cur), full 2·DW-bit product.
  - Increments i and wp (wp += 2).
  - If i reaches in_size, go to WR; else go to RD_X.
  - in_size=0 goes straight from RD_X entry to WR with acc=0.
- WR: the result is computed from acc, then written to y_base+2·j.
  - r = acc (mode 0) or acc>>>FRAC (mode 1, arithmetic).
  - If relu_en and r<0, r=0.
  - Saturate r to [−2^(DW−1), 2^(DW−1)−1].
- NEXT_J: j++, i=0, acc=0. wp carries on contiguously (row-major weights). If j=out_size go to DONE, else RD_X.
- DONE: done=1, busy=0, bus idle. start=0 returns to IDLE.
- Config port changes while busy are ignored.

## Timing
- Reset values: read_n=1, write_n=1, address=0, writedata=0, state=0, busy=0, done=0, and all internal registers 0. Reset takes effect immediately in any state, including mid-transfer.
- Read handshake:
  - Drive read_n=0 with address stable until the first cycle in which waitrequest=0.
  - On the next edge drive read_n=1 and wait, with the bus idle, for readdatavalid=1. Capture readdata in that cycle.
  - Only one read is outstanding at a time.
  - readdatavalid outside a wait phase is ignored.
- Write handshake: write_n=0 with address and writedata stable until a cycle with waitrequest=0. write_n=1 on the next edge.
- Best-case cycles per element (zero wait states, 1-cycle read latency):
  - 5 cycles: RD_X issue+data 2, RD_W 2, MAC 1.
  - 3 cycles for a skipped zero in mode 0.
  - Per output, add 1 write cycle + 1 NEXT_J cycle.
- done rises one cycle after the last write completes, or one cycle after start for out_size=0.

## Structure
- Package sdram_layer_pkg: state encoding, mode constants (MODE_BIN, MODE_MAC), default widths.
- Sub-module layer_mac_unit: holds acc. It provides clear, accumulate (mode select, skip) and a combinational post-processing output (shift, ReLU, saturate). The FSM and Avalon logic stay in the top level.

## Test plan
- mode 0, in_size=4, out_size=2, x={0,3,0,1}, w rows {1,2,3,4},{−5,6,7,8}, zero-wait slave -> writes 6 at y_base, 14 at y_base+2. Exactly 4 weight reads issued, skipped elements never read.
- mode 1, FRAC=8, x={0x0100,0x0200}, w={0x0180,0xFF00} -> y=0x0180−0x0200=0xFF80. With relu_en=1 -> 0x0000.
- Saturation: mode 1, x=w=0x7F00 repeated 4× -> y=0x7FFF. With negated weights -> y=0x8000.
- Random waitrequest (≈50 %) and readdatavalid latency 1–5 -> identical results to the zero-wait run. Address and strobes stay stable while waitrequest=1.
- out_size=0 -> no bus traffic, done=1 one cycle after start. in_size=0, out_size=3 -> three writes of 0.
- reset_n low mid-RD_W -> read_n=1, state=0 asynchronously. A stale readdatavalid afterwards is ignored, and a fresh start yields correct results.
